// File: rtl/load_store_unit.sv
// load_store_unit: one load/store over a req/gnt/rvalid data-memory port, aligned and extended for writeback
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_mem_load,
  input  logic        i_mem_wren,
  input  logic [3:0]  i_mem_size,
  input  logic        i_mem_unsign,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_addr,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic [4:0]  o_rsp_rd_addr,
  output logic        o_rsp_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_we, r_uns;
  logic [3:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic [4:0]  r_rd;
  logic        w_accept, w_bad_op, w_bad_size, w_misal, w_err;
  logic        w_src_we;
  logic [3:0]  w_src_size;
  logic [31:0] w_src_addr, w_src_wdata, w_shift, w_ext;
  logic        w_dmem_req, w_dmem_we, w_rsp_valid, w_rsp_err, w_load_done;
  logic [31:0] w_dmem_addr, w_dmem_wdata, w_rsp_rdata;
  logic [3:0]  w_dmem_be;
  logic [4:0]  w_rsp_rd_addr;

  assign o_req_ready = r_state == IDLE;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_bad_op    = i_mem_load == i_mem_wren;
  assign w_bad_size  = !(i_mem_size == 4'b0001 || i_mem_size == 4'b0011 || i_mem_size == 4'b1111);
  assign w_misal     = (i_mem_size == 4'b0011 && i_addr[0]) || (i_mem_size == 4'b1111 && i_addr[1:0] != 2'b00);
  assign w_err       = w_bad_op || w_bad_size || w_misal;

  // Request fields come straight from the inputs on the accept cycle, from the captured copy afterwards
  assign w_src_we    = o_req_ready ? i_mem_wren : r_we;
  assign w_src_size  = o_req_ready ? i_mem_size : r_size;
  assign w_src_addr  = o_req_ready ? i_addr : r_addr;
  assign w_src_wdata = o_req_ready ? i_wdata : r_wdata;

  assign w_shift = i_dmem_rdata >> {r_addr[1:0], 3'b000};
  assign w_ext   = r_size == 4'b0001 ? {{24{~r_uns & w_shift[7]}}, w_shift[7:0]}
                 : r_size == 4'b0011 ? {{16{~r_uns & w_shift[15]}}, w_shift[15:0]}
                 : w_shift;

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // Next state: errors skip the memory entirely, stores skip WAIT
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_err ? RESP : REQ) : IDLE;
      REQ:     w_next = i_dmem_gnt ? (r_we ? RESP : WAIT) : REQ;
      WAIT:    w_next = i_dmem_rvalid ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered
  always_comb begin
    w_dmem_req    = w_next == REQ;
    w_dmem_we     = w_dmem_req && w_src_we;
    w_dmem_addr   = w_dmem_req ? {w_src_addr[31:2], 2'b00} : 32'd0;
    w_dmem_be     = w_dmem_we ? w_src_size << w_src_addr[1:0] : 4'd0;
    w_dmem_wdata  = w_dmem_we ? w_src_wdata << {w_src_addr[1:0], 3'b000} : 32'd0;
    w_rsp_valid   = w_next == RESP;
    w_rsp_err     = w_rsp_valid && r_state == IDLE;
    w_load_done   = w_rsp_valid && r_state == WAIT;
    w_rsp_rdata   = w_load_done ? w_ext : 32'd0;
    w_rsp_rd_addr = w_load_done ? r_rd : 5'd0;
  end

  // Capture the operation on accept so the pipeline inputs may change afterwards
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rd    <= 5'd0;
    end else if (w_accept) begin
      r_we    <= i_mem_wren;
      r_uns   <= i_mem_unsign;
      r_size  <= i_mem_size;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_rd    <= i_rd_addr;
    end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_dmem_req    <= 1'b0;
      o_dmem_we     <= 1'b0;
      o_dmem_addr   <= 32'd0;
      o_dmem_be     <= 4'd0;
      o_dmem_wdata  <= 32'd0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= 32'd0;
      o_rsp_rd_addr <= 5'd0;
      o_rsp_err     <= 1'b0;
    end else begin
      o_dmem_req    <= w_dmem_req;
      o_dmem_we     <= w_dmem_we;
      o_dmem_addr   <= w_dmem_addr;
      o_dmem_be     <= w_dmem_be;
      o_dmem_wdata  <= w_dmem_wdata;
      o_rsp_valid   <= w_rsp_valid;
      o_rsp_rdata   <= w_rsp_rdata;
      o_rsp_rd_addr <= w_rsp_rd_addr;
      o_rsp_err     <= w_rsp_err;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Executes the data-memory access for one load or store from the pipeline. It consumes the memory controls produced by instruction decode (`mem_load`, `mem_wren`, `mem_size`, `mem_unsign`), plus the ALU-computed address and the rs2 store data. It drives a request/grant/rvalid data-memory port and returns an aligned, sign- or zero-extended load result for writeback. It sits between execute and writeback and holds the pipeline through `req_ready` while an access is outstanding.

## Interface
Parameters:
- none. Data and address are fixed at 32 bits (RV32).

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  pipeline presents a memory operation.
- `req_ready`  out  1  equals `state==IDLE`. The request is accepted on `req_valid && req_ready`.
- `mem_load`  in  1  load operation.
- `mem_wren`  in  1  store operation.
- `mem_size`  in  4  access size. 4'b0001 = byte, 4'b0011 = halfword, 4'b1111 = word. Any other value is illegal.
- `mem_unsign`  in  1  zero-extend the load result. Ignored for word loads and for stores.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned (rs2).
- `rd_addr`  in  5  load destination register.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  32  word-aligned address: `{addr[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-shifted store data.
- `dmem_gnt`  in  1  memory accepted the request.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read data, word-aligned.
- `rsp_valid`  out  1  single-cycle completion pulse.
- `rsp_rdata`  out  32  extended load data. 0 for stores and errors.
- `rsp_rd_addr`  out  5  captured `rd_addr` for loads. 0 for stores.
- `rsp_err`  out  1  the access was misaligned or illegal. No memory access was issued.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **On accept in IDLE**, capture all inputs, then check legality:
  - Illegal if both `mem_load` and `mem_wren` are set, or neither is set.
  - Illegal if `mem_size` is not one of the three legal codes.
  - Misaligned if a halfword has `addr[0]=1`, or a word has `addr[1:0]!=0`.
  - Illegal or misaligned: go to RESP with `rsp_err=1`. No `dmem_req` is issued.
  - Legal: go to REQ.
- **REQ**:
  - Drive `dmem_req=1` with constant `dmem_we`, `dmem_addr`, `dmem_be`, `dmem_wdata` until `dmem_gnt`.
  - On gnt, a store goes to RESP and a load goes to WAIT.
- **WAIT**: a load goes to RESP on `dmem_rvalid`. `dmem_rvalid` is sampled only in WAIT; it is ignored in every other state.
- **RESP**: `rsp_valid=1` for exactly one cycle, then IDLE.
- **Byte enables**: `dmem_be = mem_size << addr[1:0]`.
- **Store data**: `dmem_wdata = wdata << (8*addr[1:0])`. Lanes outside `dmem_be` are don't-care, but the bench expects the shifted value.
- **Load extraction**: `s = dmem_rdata >> (8*addr[1:0])`.
  - Byte: extend `s[7:0]`.
  - Halfword: extend `s[15:0]`.
  - Word: `s` unchanged.
  - Extension is zero when `mem_unsign=1`, otherwise sign.
  - The result is registered into `rsp_rdata` on entry to RESP.
- **Output registration**: all `dmem_*` and `rsp_*` outputs are registered. They are 0 outside their active states, and `dmem_we`/`dmem_be` are 0 when `dmem_req=0`.
- **Reset** (any time, including mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0 immediately, except `req_ready`, which is 1.
  - A granted but unreturned load is abandoned. Its late `dmem_rvalid` arrives in IDLE and is ignored.

## Timing
- Accept edge = T.
- Load, zero-wait memory: `dmem_req` high in cycle T+1 with gnt, WAIT in T+2 with rvalid, `rsp_valid` in T+3. Minimum latency 3 cycles.
- Store, zero-wait memory: `dmem_req` in T+1 with gnt, `rsp_valid` in T+2. Minimum latency 2 cycles.
- Error: `rsp_valid` with `rsp_err` in T+1. No `dmem_req` pulse.
- Each cycle of gnt delay adds one REQ cycle. Each cycle of rvalid delay adds one WAIT cycle.
- `req_ready` is low from T+1 through the RESP cycle and high again the cycle after RESP.
- Back-to-back: a new request may be accepted in the cycle after RESP. Throughput is at most one access per 3 cycles (stores) or 4 cycles (loads).
- `dmem_gnt` outside REQ and `dmem_rvalid` outside WAIT have no effect.

## Test plan
- **Signed byte load**: LB with addr=0x1002, rdata=0x80FF_1234 → `dmem_be`=0000 (no write), `dmem_addr`=0x1000, `rsp_rdata`=0xFFFF_FFFF, `rsp_rd_addr` captured, `rsp_valid` at T+3.
- **Unsigned halfword load**: LHU with addr=0x2002, rdata=0x8001_0000 → `rsp_rdata`=0x0000_8001. Same access as LH → 0xFFFF_8001.
- **Stores**:
  - SB with addr=0x3003, wdata=0x0000_00AB → `dmem_be`=1000, `dmem_wdata`=0xAB00_0000, `dmem_we`=1.
  - SW with 2-cycle-late gnt → `dmem_req` held 3 cycles with constant fields, `rsp_valid` at T+4.
- **Errors**:
  - LW with addr=0x4001 → `rsp_err=1` at T+1, `dmem_req` never asserted.
  - `mem_size`=4'b0010 → same error response.
  - `mem_load`=`mem_wren`=1 → same error response.
- **Handshake corners**:
  - rvalid delayed 4 cycles → `req_ready` stays low until `rsp_valid`.
  - Spurious gnt/rvalid pulses in IDLE → no state change.
- **Reset mid-operation**: `rst_n` low while in WAIT → all outputs 0 asynchronously and `req_ready`=1. After release, a late `dmem_rvalid` produces no `rsp_valid`, and the next LW completes normally.
